bcd_counter_ndigit: RTL and testbench
=====================================

// Module: bcd_counter_ndigit
// PURPOSE
// Parametrised multi-digit BCD counter, successor to the single-digit BCD counter.
// Counts up or down in decimal over DIGITS packed BCD digits, with parallel load and wrap/saturate mode.
// Flags terminal count and emits a cascade carry for chaining.
// Used as a display/event counter wherever a decimal count must be shown directly.
// PARAMETERS
// DIGITS  4  number of BCD digits (1..8); Q is 4*DIGITS bits, digit 0 = LSBs
// WRAP    1  1: wrap at terminal count (99..9 -> 0, 0 -> 99..9); 0: saturate and hold at terminal
// PORTS
// clk         in   1          rising-edge clock
// reset       in   1          synchronous, active-high reset
// enable      in   1          count one step on this clock edge when high
// up_dn       in   1          1 = count up, 0 = count down; sampled with enable
// load        in   1          parallel load request; load_value is sampled on the same edge
// load_value  in   4*DIGITS   packed BCD value to load
// Q           out  4*DIGITS   current count, packed BCD, registered
// done        out  1          terminal count for current direction (combinational from Q, up_dn)
// carry_out   out  1          cascade strobe: enable & done & ~load (combinational)
// load_err    out  1          registered 1-cycle pulse: load rejected, a load_value digit > 9
// BEHAVIOUR
// - Reset (sampled at clk edge while reset=1): Q=0, load_err=0; reset has top priority, overrides load/enable.
// - Priority per edge: reset > load > enable > hold.
// - load=1: if every digit of load_value <= 9, Q <= load_value next edge, load_err <= 0;
//   else Q holds and load_err <= 1 for exactly one cycle. enable is ignored on a load cycle either way.
// - enable=1, load=0, up_dn=1: digit 0 increments; digit k increments only when digits 0..k-1 are all 9,
//   and any digit at 9 that increments becomes 0. Latency: new Q visible one cycle after the edge.
// - enable=1, load=0, up_dn=0: digit 0 decrements; digit k decrements only when digits 0..k-1 are all 0,
//   and any digit at 0 that decrements becomes 9.
// - Terminal count: up -> all digits 9; down -> all digits 0. done = (Q == terminal for current up_dn).
// - At terminal with enable=1: WRAP=1 -> Q rolls to 0 (up) or all 9s (down); WRAP=0 -> Q holds.
// - carry_out asserts in the cycle before the roll/hold edge regardless of WRAP; used as downstream enable.
// - up_dn may change any cycle; done/carry_out follow it combinationally; no pending state is kept.
// - enable=0: Q holds; done still reflects Q; carry_out=0.
// - Q never holds a non-BCD digit: only reachable values are 0..(10^DIGITS - 1).
// - Reset asserted mid-count or mid-load: Q=0 on that edge; pending load is discarded.
// - No internal state beyond Q and load_err register; no FSM beyond the digit ripple logic.
// TESTING (DIGITS=2 unless noted)
// 1. reset=1 for 2 cycles, then enable=1, up_dn=1 for 12 cycles -> Q steps 00..09,10,11,12; done=0 throughout.
// 2. load 8'h98, then enable up 3 cycles, WRAP=1 -> Q 98,99,00; done=1 and carry_out=1 only while Q=99.
// 3. load 8'h01, enable down 3 cycles, WRAP=0 -> Q 01,00,00; done=1 while Q=00; Q holds at 00.
// 4. load 8'h3A -> Q unchanged, load_err=1 for exactly one cycle; load and enable same cycle with 8'h45 -> Q=45, no count.
// 5. enable up from 8'h55, assert reset on third cycle with load=1 -> Q=00 next edge, load_err=0.
// 6. DIGITS=4, two-stage chain (stage B enable = stage A carry_out), load A=9999 -> one enable step: A=0000, B=0001.

Source files
------------

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit packed BCD up/down counter with parallel load, wrap/saturate at
// terminal count, and a cascade carry strobe for chaining stages.
module bcd_counter_ndigit #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  done,
    output logic                  carry_out,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_next;
    logic [3:0]          digit;
    logic                ripple;
    logic                load_ok;
    logic                all_nine;
    logic                all_zero;

    // ripple tracks whether every lower digit sits at its rollover value,
    // which is exactly the condition for the current digit to step
    always_comb begin
        count_next = Q;
        digit      = 4'd0;
        ripple     = 1'b1;
        load_ok    = 1'b1;
        all_nine   = 1'b1;
        all_zero   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            digit = Q[4*k +: 4];
            if (ripple) begin
                if (up_dn) begin
                    count_next[4*k +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                end else begin
                    count_next[4*k +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                end
            end
            ripple   = ripple & (up_dn ? (digit == 4'd9) : (digit == 4'd0));
            all_nine = all_nine & (digit == 4'd9);
            all_zero = all_zero & (digit == 4'd0);
            if (load_value[4*k +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    assign done      = up_dn ? all_nine : all_zero;
    assign carry_out = enable & done & ~load;

    always_ff @(posedge clk) begin
        if (reset) begin
            Q        <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    Q <= load_value;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (enable && !(done && !WRAP)) begin
                // at terminal count the ripple already produces the wrapped value
                Q <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench: 2-digit wrap and saturate counters share stimulus, plus a
// 4-digit two-stage chain driven through the cascade carry.
module tb_bcd_counter_ndigit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        up_dn;
    logic        load;
    logic [7:0]  load_value;

    logic [7:0]  q_w, q_s;
    logic        done_w, carry_w, err_w;
    logic        done_s, carry_s, err_s;

    logic        a_enable, a_up_dn, a_load;
    logic [15:0] a_load_value;
    logic [15:0] q_a, q_b;
    logic        done_a, carry_a, err_a;
    logic        done_b, carry_b, err_b;
    logic        b_up_dn = 1'b1;
    logic        b_load = 1'b0;
    logic [15:0] b_load_value = 16'h0000;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_value(load_value), .Q(q_w), .done(done_w), .carry_out(carry_w), .load_err(err_w)
    );

    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_value(load_value), .Q(q_s), .done(done_s), .carry_out(carry_s), .load_err(err_s)
    );

    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .up_dn(a_up_dn), .load(a_load),
        .load_value(a_load_value), .Q(q_a), .done(done_a), .carry_out(carry_a), .load_err(err_a)
    );

    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(carry_a), .up_dn(b_up_dn), .load(b_load),
        .load_value(b_load_value), .Q(q_b), .done(done_b), .carry_out(carry_b), .load_err(err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_value = 8'h00;
        a_enable = 1'b0; a_up_dn = 1'b1; a_load = 1'b0; a_load_value = 16'h0000;

        // reset state
        step(); step();
        check_output("reset_q_w", 16'(q_w), 16'h00);
        check_output("reset_q_s", 16'(q_s), 16'h00);
        check_output("reset_err_w", 16'(err_w), 16'h0);
        check_output("reset_done_w", 16'(done_w), 16'h0);
        check_output("reset_q_a", q_a, 16'h0000);
        check_output("reset_q_b", q_b, 16'h0000);

        // count up 12 steps through the digit-0 rollover
        reset = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_output($sformatf("up_q_w_%0d", i), 16'(q_w), 16'(((i / 10) << 4) | (i % 10)));
            check_output($sformatf("up_q_s_%0d", i), 16'(q_s), 16'(((i / 10) << 4) | (i % 10)));
            check_output($sformatf("up_done_%0d", i), 16'(done_w), 16'h0);
        end

        // load 98 then count up through terminal
        enable = 1'b0; load = 1'b1; load_value = 8'h98;
        step();
        check_output("load98_q_w", 16'(q_w), 16'h98);
        check_output("load98_q_s", 16'(q_s), 16'h98);
        load = 1'b0; enable = 1'b1;
        #1;
        check_output("q98_carry_w", 16'(carry_w), 16'h0);
        step();
        check_output("q99_q_w", 16'(q_w), 16'h99);
        check_output("q99_done_w", 16'(done_w), 16'h1);
        check_output("q99_carry_w", 16'(carry_w), 16'h1);
        check_output("q99_carry_s", 16'(carry_s), 16'h1);
        step();
        check_output("wrap_q_w", 16'(q_w), 16'h00);
        check_output("wrap_done_w", 16'(done_w), 16'h0);
        check_output("wrap_carry_w", 16'(carry_w), 16'h0);
        check_output("sat_q_s", 16'(q_s), 16'h99);
        check_output("sat_done_s", 16'(done_s), 16'h1);
        step();
        check_output("wrap_q_w_01", 16'(q_w), 16'h01);
        check_output("sat_q_s_hold", 16'(q_s), 16'h99);

        // load 01 then count down through zero
        enable = 1'b0; load = 1'b1; load_value = 8'h01;
        step();
        check_output("load01_q_s", 16'(q_s), 16'h01);
        load = 1'b0; up_dn = 1'b0; enable = 1'b1;
        #1;
        check_output("q01_done_s", 16'(done_s), 16'h0);
        step();
        check_output("down_q_s_00", 16'(q_s), 16'h00);
        check_output("down_done_s", 16'(done_s), 16'h1);
        check_output("down_carry_s", 16'(carry_s), 16'h1);
        check_output("down_q_w_00", 16'(q_w), 16'h00);
        step();
        check_output("down_sat_q_s", 16'(q_s), 16'h00);
        check_output("down_wrap_q_w", 16'(q_w), 16'h99);
        check_output("down_q99_done_w", 16'(done_w), 16'h0);
        up_dn = 1'b1;
        #1;
        check_output("dir_done_w", 16'(done_w), 16'h1);
        check_output("dir_done_s", 16'(done_s), 16'h0);
        check_output("dir_carry_s", 16'(carry_s), 16'h0);
        enable = 1'b0;
        #1;
        check_output("noen_carry_w", 16'(carry_w), 16'h0);
        check_output("noen_done_w", 16'(done_w), 16'h1);

        // invalid load rejected, then load beats enable
        load = 1'b1; load_value = 8'h3A;
        step();
        check_output("badload_q_w", 16'(q_w), 16'h99);
        check_output("badload_err_w", 16'(err_w), 16'h1);
        check_output("badload_err_s", 16'(err_s), 16'h1);
        load = 1'b0;
        step();
        check_output("badload_err_clear", 16'(err_w), 16'h0);
        check_output("badload_q_s", 16'(q_s), 16'h00);
        load = 1'b1; enable = 1'b1; load_value = 8'h45;
        #1;
        check_output("loadcyc_carry_w", 16'(carry_w), 16'h0);
        step();
        check_output("load45_q_w", 16'(q_w), 16'h45);
        check_output("load45_q_s", 16'(q_s), 16'h45);
        check_output("load45_err", 16'(err_w), 16'h0);

        // reset overrides a pending (invalid) load mid-count
        load_value = 8'h55; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        check_output("from55_q_w", 16'(q_w), 16'h56);
        step();
        check_output("from55_q_w2", 16'(q_w), 16'h57);
        reset = 1'b1; load = 1'b1; load_value = 8'hA3;
        step();
        check_output("midreset_q_w", 16'(q_w), 16'h00);
        check_output("midreset_q_s", 16'(q_s), 16'h00);
        check_output("midreset_err_w", 16'(err_w), 16'h0);
        reset = 1'b0; load = 1'b0; enable = 1'b0;

        // 4-digit chain: A carry enables B
        a_load = 1'b1; a_load_value = 16'h9999;
        step();
        check_output("a_load_9999", q_a, 16'h9999);
        a_load = 1'b0; a_enable = 1'b1;
        #1;
        check_output("a_carry", 16'(carry_a), 16'h1);
        step();
        check_output("chain_q_a", q_a, 16'h0000);
        check_output("chain_q_b", q_b, 16'h0001);
        check_output("chain_done_b", 16'(done_b), 16'h0);
        check_output("chain_carry_b", 16'(carry_b), 16'h0);
        a_enable = 1'b0; a_load = 1'b1; a_load_value = 16'h0999;
        step();
        a_load = 1'b0; a_enable = 1'b1;
        step();
        check_output("a_ripple_up", q_a, 16'h1000);
        a_up_dn = 1'b0;
        step();
        check_output("a_ripple_down", q_a, 16'h0999);
        check_output("a_down_q_b", q_b, 16'h0001);
        a_enable = 1'b0; a_load = 1'b1; a_load_value = 16'hF000;
        step();
        check_output("a_badload_q", q_a, 16'h0999);
        check_output("a_badload_err", 16'(err_a), 16'h1);
        check_output("b_err", 16'(err_b), 16'h0);
        check_output("a_done_down", 16'(done_a), 16'h0);
        a_load = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
